// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared types and helpers for the data memory responder.
//   data_t / addr_t   : 32-bit data word and byte address
//   mem_rsp_state_t   : responder FSM states
//   BE_WORD           : full-word byte-lane enable
//   be_legal()        : byte-enable / address-alignment legality check. It is
//                       only called when MEM_RESP_ERR_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package mem_resp_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_rsp_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // Returns 1 when be is a byte, halfword or word pattern that matches the
    // low address bits.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (be)
            4'b0001:    ok = (addr_lo == 2'd0);
            4'b0010:    ok = (addr_lo == 2'd1);
            4'b0100:    ok = (addr_lo == 2'd2);
            4'b1000:    ok = (addr_lo == 2'd3);
            BE_HALF_LO: ok = (addr_lo == 2'd0);
            BE_HALF_HI: ok = (addr_lo == 2'd2);
            BE_WORD:    ok = (addr_lo == 2'd0);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// -----------------------------------------------------------------------------
// mem_resp_ram
// DEPTH x 32-bit synchronous RAM organised as four byte lanes, one read/write
// port. The read is registered (1-cycle latency) and read-first: a read and a
// write to the same word in the same cycle return the old contents. The read
// register only loads when en_i is high, so its output holds between accesses.
// Ports:
//   clk_i    in   clock
//   en_i     in   port enable (read capture and optional write)
//   we_i     in   write enable
//   addr_i   in   word address
//   be_i     in   byte-lane write enables
//   wdata_i  in   lane-positioned write data
//   rdata_o  out  registered read word
// Contents are not reset.
// -----------------------------------------------------------------------------
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  data_t         wdata_i,
    output data_t         rdata_o
);

    logic [3:0][7:0] mem_q [DEPTH];
    data_t           rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][i] <= wdata_i[8*i +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the LSU load/store path. Accepts one request at a
// time, commits byte-masked stores at acceptance, captures load data at
// acceptance and presents the response LATENCY cycles later on a valid/ready
// channel.
// Parameters:
//   DEPTH    number of 32-bit words (power of 2)
//   LATENCY  cycles from acceptance to rsp_valid_o (1..15)
// Ports:
//   clk_i        in   core clock
//   reset_i      in   asynchronous active-high reset
//   req_valid_i  in   request present
//   req_ready_o  out  responder idle, can accept
//   req_we_i     in   1 = store, 0 = load
//   req_addr_i   in   byte address
//   req_be_i     in   byte-lane enables
//   req_wdata_i  in   lane-positioned store data
//   rsp_valid_o  out  response present
//   rsp_ready_i  in   requester takes the response
//   rsp_rdata_o  out  read word, 0 for stores and errored accesses
//   rsp_err_o    out  access rejected
// Build option:
//   MEM_RESP_ERR_CHECK_EN  when defined, illegal byte enables, misaligned
//                          enables and out-of-range addresses are rejected with
//                          rsp_err_o=1 and no RAM access. When undefined the
//                          address wraps modulo DEPTH*4 and rsp_err_o is 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | req_ready_o=1, waiting for a request
// ACCESS | latency countdown, count_q cycles left before RESP
// RESP   | rsp_valid_o=1, response held until rsp_ready_i
// -----------------------------------------------------------------------------
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_we_i,
    input  addr_t      req_addr_i,
    input  logic [3:0] req_be_i,
    input  data_t      req_wdata_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output data_t      rsp_rdata_o,
    output logic       rsp_err_o
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    mem_rsp_state_t state_q, state_d;
    logic [3:0]     count_q, count_d;
    logic           err_q, err_d;
    logic           load_q, load_d;

    logic           accept;
    logic           acc_err;
    logic           ram_en;
    data_t          ram_rdata;

    // ------------------------------------------------------------------
    // Access legality
    // ------------------------------------------------------------------
`ifdef MEM_RESP_ERR_CHECK_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

    logic addr_oob;
    assign addr_oob = ({1'b0, req_addr_i} >= ADDR_LIMIT);
    assign acc_err  = !be_legal(req_be_i, req_addr_i[1:0]) || addr_oob;
`else
    // Without checking, upper address bits are dropped (wrap) and the byte
    // offset plays no part in indexing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};
    assign acc_err          = 1'b0;
`endif

    assign accept = req_valid_i && (state_q == IDLE);

    // Rejected accesses never touch the RAM, so an errored store writes
    // nothing and the read register keeps its previous contents.
    assign ram_en = accept && !acc_err;

    mem_resp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (req_we_i),
        .addr_i  (req_addr_i[AW+1:2]),
        .be_i    (req_be_i),
        .wdata_i (req_wdata_i),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        load_d  = load_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d  = acc_err;
                    // Only a successful load returns RAM data; everything else
                    // reports a zero word.
                    load_d = !req_we_i && !acc_err;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        count_d = 4'd0;
                    end else begin
                        state_d = ACCESS;
                        count_d = LAT_M1;
                    end
                end
            end
            ACCESS: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = err_q;
    // The RAM read register only reloads on the next acceptance, so the word
    // is stable for the whole response phase.
    assign rsp_rdata_o = load_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    import mem_resp_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata [2];

    always #5 clk = ~clk;

    // dut0: LATENCY=2, dut1: LATENCY=1. Request fields, reset and rsp_ready
    // are shared; each instance has its own req_valid.
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_be_i(req_be),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_be_i(req_be),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    exp_t expq [2][$];
    vec_t vecs [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a response is consumed at the edge following a negedge where
    // rsp_valid && rsp_ready; compare it against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (!reset && rsp_valid[s] && rsp_ready) begin
                if (expq[s].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp dut%0d: got rdata %08h, expected no response", s, rsp_rdata[s]);
                end else begin
                    e = expq[s].pop_front();
                    chk($sformatf("rdata dut%0d", s), rsp_rdata[s], e.rdata);
                    chk($sformatf("err dut%0d", s), {31'b0, rsp_err[s]}, {31'b0, e.err});
                    if (e.chk_lat)
                        chk($sformatf("latency dut%0d", s), 32'(cyc - e.acc_cyc + 1), (s == 0) ? 32'd2 : 32'd1);
                end
            end
        end
    end

    task automatic send(input int s, input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err,
                        input bit chk_lat, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        req_valid[s] = 1'b1;
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: req_ready stayed 0, expected 1 within 50 cycles", s);
            req_valid[s] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        if (push) begin
            e.rdata   = exp_rdata;
            e.err     = exp_err;
            e.acc_cyc = cyc;
            e.chk_lat = chk_lat;
            expq[s].push_back(e);
        end
    endtask

    task automatic drain(input int s);
        int n;
        n = 0;
        while (expq[s].size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout dut%0d: %0d responses outstanding, expected 0", s, expq[s].size());
            expq[s].delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  model [256];
        logic [3:0]  be_tab [7];
        logic [1:0]  lo_tab [7];
        logic [31:0] d, exp_w;
        int          w, k;
        bit          we;

        be_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        lo_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};

        reset     = 1'b1;
        req_valid = 2'b00;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset req_ready dut%0d", s), {31'b0, req_ready[s]}, 32'd1);
            chk($sformatf("reset rsp_valid dut%0d", s), {31'b0, rsp_valid[s]}, 32'd0);
            chk($sformatf("reset rsp_rdata dut%0d", s), rsp_rdata[s], 32'd0);
            chk($sformatf("reset rsp_err dut%0d", s), {31'b0, rsp_err[s]}, 32'd0);
        end
        reset = 1'b0;

        // ---------------- table-driven vectors on dut0 (LATENCY=2) ----------------
        vecs.push_back('{1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h12, 4'b0100, 32'h00AA0000, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10, 4'b1111, 32'h0,        32'hDEAABEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h13, 4'b1000, 32'h0,        32'hDEAABEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h14, 4'b1111, 32'h11223344, 32'h0,        1'b0});
`ifdef MEM_RESP_ERR_CHECK_EN
        vecs.push_back('{1'b1, 32'h14, 4'b0000, 32'hFFFFFFFF, 32'h0,        1'b1});
`else
        vecs.push_back('{1'b1, 32'h14, 4'b0000, 32'hFFFFFFFF, 32'h0,        1'b0});
`endif
        vecs.push_back('{1'b0, 32'h14, 4'b1111, 32'h0,        32'h11223344, 1'b0});
        vecs.push_back('{1'b1, 32'h18, 4'b0011, 32'h0000BEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h1A, 4'b1100, 32'h12340000, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h18, 4'b1111, 32'h0,        32'h1234BEEF, 1'b0});
`ifdef MEM_RESP_ERR_CHECK_EN
        vecs.push_back('{1'b1, 32'h11, 4'b0011, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h10, 4'b0101, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h1000, 4'b1111, 32'hFFFFFFFF, 32'h0,      1'b1});
        vecs.push_back('{1'b0, 32'h10, 4'b1111, 32'h0,        32'hDEAABEEF, 1'b0});
        vecs.push_back('{1'b0, DEPTH * 4, 4'b1111, 32'h0,     32'h0,        1'b1});
        vecs.push_back('{1'b0, DEPTH * 4 + 32'h10, 4'b1111, 32'h0, 32'h0,   1'b1});
`else
        vecs.push_back('{1'b0, DEPTH * 4 + 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0});
        vecs.push_back('{1'b1, DEPTH * 4 + 32'h14, 4'b0001, 32'h000000AB, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h14, 4'b1111, 32'h0,        32'h112233AB, 1'b0});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            send(0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].exp_err, 1'b1, 1'b1);
        end
        drain(0);

        // ---------------- response backpressure ----------------
        rsp_ready = 1'b0;
        send(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0, 1'b0, 1'b1);
        k = 0;
        while (!rsp_valid[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
            chk("bp rsp_rdata", rsp_rdata[0], 32'hDEAABEEF);
            chk("bp rsp_err", {31'b0, rsp_err[0]}, 32'd0);
            chk("bp req_ready", {31'b0, req_ready[0]}, 32'd0);
            if (i == 1) begin
                req_we       = 1'b1;
                req_addr     = 32'h10;
                req_be       = 4'b1111;
                req_wdata    = 32'h12345678;
                req_valid[0] = 1'b1;
            end else begin
                req_valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp release req_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("bp release rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        send(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0, 1'b1, 1'b1);
        drain(0);

        // ---------------- reset during ACCESS of a load ----------------
        send(0, 1'b1, 32'h24, 4'b1111, 32'h5A5A1234, 32'h0, 1'b0, 1'b1, 1'b1);
        drain(0);
        send(0, 1'b0, 32'h24, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid-reset rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("mid-reset req_ready", {31'b0, req_ready[0]}, 32'd1);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post-reset rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        send(0, 1'b0, 32'h24, 4'b1111, 32'h0, 32'h5A5A1234, 1'b0, 1'b1, 1'b1);
        drain(0);

        // ---------------- LATENCY=1 random sweep on dut1 ----------------
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            for (int b = 0; b < 4; b++) model[i*4 + b] = d[8*b +: 8];
            send(1, 1'b1, 32'(i * 4), 4'b1111, d, 32'h0, 1'b0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 100; i++) begin
            w  = $urandom_range(0, 63);
            k  = $urandom_range(0, 6);
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be_tab[k][b]) model[w*4 + b] = d[8*b +: 8];
                exp_w = 32'h0;
            end else begin
                for (int b = 0; b < 4; b++) exp_w[8*b +: 8] = model[w*4 + b];
            end
            send(1, we, 32'(w * 4) + 32'(lo_tab[k]), be_tab[k], d, exp_w, 1'b0, 1'b1, 1'b1);
        end
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
